ram_nibble_array: RTL and testbench
===================================

// Module: ram_nibble_array
// PURPOSE
// - Parametrised single-port word RAM, DEPTH x WIDTH, built from 4-bit lanes; successor to the fixed 2x8 array.
// - Adds per-nibble write enables, a registered read with valid strobe, a req/ready handshake,
//   out-of-range error flag, and a sequenced INIT sweep that fills every word with a pattern.
// - Sits as the general-purpose data memory beside the register-file and datapath blocks.
// PARAMETERS
// - WIDTH     8     word width in bits; must be a multiple of 4 (lanes = WIDTH/4)
// - DEPTH     2     number of words; any value >= 2 (need not be a power of two)
// - INIT_VAL  0     WIDTH-bit pattern written to every word by an INIT sweep
// - ADDR_W    localparam = max(1, $clog2(DEPTH))
// - LANES     localparam = WIDTH/4
// PORTS
// - clk       in   1        rising-edge clock
// - clr       in   1        asynchronous active-high reset; clears all storage and state
// - req       in   1        access request; sampled when ready=1
// - rw        in   1        1 = write, 0 = read
// - addr      in   ADDR_W   word address
// - nib_en    in   LANES    per-nibble write enable (bit i -> data_in[4i+3:4i]); ignored on reads
// - data_in   in   WIDTH    write data
// - init      in   1        start INIT sweep (level sampled in IDLE)
// - ready     out  1        1 when an access can be accepted (state IDLE and init=0)
// - data_out  out  WIDTH    registered read data; holds last read value until the next read completes
// - rvalid    out  1        one-cycle pulse: data_out updated this cycle
// - err       out  1        one-cycle pulse: accepted access had addr >= DEPTH
// - busy      out  1        1 while INIT sweep in progress
// BEHAVIOUR
// - Reset (clr=1, async): all words = 0, data_out = 0, rvalid = 0, err = 0, busy = 0, state = IDLE, sweep ptr = 0.
//   clr overrides everything, including mid-sweep; after release the block is in IDLE with the array all-zero.
// - FSM states: IDLE, SWEEP (encoding in package).
//   IDLE --init=1--> SWEEP (ptr=0, busy=1). SWEEP: each cycle write INIT_VAL to word[ptr], ptr++;
//   at ptr==DEPTH-1 write last word and return to IDLE next edge (busy=0). Sweep = exactly DEPTH cycles.
// - ready = (state==IDLE) && !init (combinational). accept = req && ready.
// - init and req asserted together in IDLE: init wins, req not accepted; requester must hold req.
// - init asserted during SWEEP: ignored (no restart). req during SWEEP: ignored, no rvalid/err.
// - Write accept: at the edge, for each lane i with nib_en[i]=1, word[addr][4i+3:4i] <= data_in lane; other lanes keep value.
//   nib_en all-zero write is legal and changes nothing. No rvalid on writes.
// - Read accept: data_out <= word[addr] at the edge; rvalid=1 for that following cycle (latency 1).
// - Write then read same addr on next cycle returns the newly written data.
// - Back-to-back reads every cycle are sustained: rvalid stays high for consecutive accepted reads.
// - addr >= DEPTH (only possible when DEPTH not a power of two): write has no effect; read sets
//   data_out = 0 with rvalid=1; err pulses 1 cycle after accept in both cases.
// - ptr is ADDR_W bits; never wraps past DEPTH-1.
// STRUCTURE
// - Package ram_pkg: state enum (IDLE, SWEEP), lane width constant NIB_W = 4, clog2 helper for ADDR_W.
// - Sub-module ram_nibble_word: one WIDTH-bit word of LANES 4-bit lanes with async clr, load enable,
//   per-lane enable and load mux (data_in or INIT_VAL); instantiated DEPTH times via generate.
// - Top holds FSM, sweep pointer, address decode, read mux and output registers.
// TESTING
// - Reset: pulse clr mid-cycle with WIDTH=8,DEPTH=2 -> data_out=0, busy=0, ready=1; read addr 0,1 -> 8'h00 each.
// - Write/read: write 8'hA5 to addr 1 (nib_en=2'b11), read addr 1 next cycle -> rvalid=1 one cycle later, data_out=8'hA5.
// - Nibble enables: word=8'h3C, write 8'hF0 with nib_en=2'b10 -> read returns 8'hFC; nib_en=2'b00 -> unchanged.
// - INIT sweep: INIT_VAL=8'h5A, DEPTH=5, pulse init -> busy high exactly 5 cycles, ready low; all 5 words read 8'h5A;
//   req held during sweep accepted only on first IDLE cycle.
// - Out of range: DEPTH=5, ADDR_W=3, write addr 6 then read addr 6 -> err pulses twice, data_out=0, words 0-4 unchanged.
// - clr mid-sweep: assert clr at ptr=2 of DEPTH=5 sweep -> busy=0 immediately, all words read 0 after release, init restartable.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the nibble-lane RAM
// Purpose: FSM state encoding, lane width and address-width helper used by
//          ram_nibble_array and ram_nibble_word.
// Ports:   none (package).
package ram_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Address width for a given depth, never below one bit.
  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_nibble_word.sv
// rtl/ram_nibble_word.sv - one RAM word made of independently writable 4-bit lanes
// Purpose: holds a WIDTH-bit word; on load, each enabled lane takes either the
//          write data or the INIT_VAL pattern.
// Ports:   clk      - rising-edge clock
//          clr      - asynchronous active-high clear (word -> 0)
//          load     - write this word at the edge
//          lane_en  - per-lane enable, bit i covers bits [4i+3:4i]
//          sel_init - 1: load INIT_VAL, 0: load data_in
//          data_in  - write data
//          q        - stored word
module ram_nibble_word
  import ram_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              LANES    = WIDTH / NIB_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [LANES-1:0] lane_en,
  input  logic             sel_init,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] load_val;

  assign load_val = sel_init ? INIT_VAL : data_in;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          q[i*NIB_W +: NIB_W] <= load_val[i*NIB_W +: NIB_W];
        end
      end
    end
  end

endmodule

// File: rtl/ram_nibble_array.sv
// rtl/ram_nibble_array.sv - DEPTH x WIDTH single-port RAM with nibble enables and INIT sweep
// Purpose: general-purpose data memory; req/ready access, registered read with
//          rvalid strobe, out-of-range err pulse, and a DEPTH-cycle INIT fill.
// Ports:   clk      - rising-edge clock
//          clr      - asynchronous active-high reset of storage and state
//          req      - access request, taken when ready=1
//          rw       - 1 write, 0 read
//          addr     - word address
//          nib_en   - per-nibble write enable (ignored on reads)
//          data_in  - write data
//          init     - start INIT sweep (sampled in IDLE)
//          ready    - access can be accepted this cycle
//          data_out - registered read data, held until the next read
//          rvalid   - one-cycle pulse when data_out was updated
//          err      - one-cycle pulse after an accepted access with addr >= DEPTH
//          busy     - INIT sweep in progress
module ram_nibble_array
  import ram_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              ADDR_W   = addr_bits(DEPTH),
  localparam int              LANES    = WIDTH / NIB_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  nib_en,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              init,
  output logic              ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              sweeping;
  logic              accept;
  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  words [DEPTH];
  logic [WIDTH-1:0]  rd_word;

  assign sweeping = (state == ST_SWEEP);
  assign ready    = !sweeping && !init;
  assign busy     = sweeping;
  assign accept   = req && ready;
  assign in_range = int'(addr) < DEPTH;
  assign wr_acc   = accept && rw && in_range;
  assign rd_acc   = accept && !rw;

  // FSM: state and sweep pointer registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Sweep occupies exactly DEPTH cycles: words 0..DEPTH-1, one per cycle.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (init) begin
          state_nxt = ST_SWEEP;
          ptr_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Storage: the sweep owns the write port while active, so accepted writes
  // and sweep writes never collide.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic             load;
    logic [LANES-1:0] lane_en;

    assign load    = sweeping ? (ptr == ADDR_W'(g)) : (wr_acc && (addr == ADDR_W'(g)));
    assign lane_en = sweeping ? '1 : nib_en;

    ram_nibble_word #(
      .WIDTH    (WIDTH),
      .INIT_VAL (INIT_VAL)
    ) u_word (
      .clk      (clk),
      .clr      (clr),
      .load     (load),
      .lane_en  (lane_en),
      .sel_init (sweeping),
      .data_in  (data_in),
      .q        (words[g])
    );
  end

  // Read mux: an address past DEPTH matches no word and reads as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_word = words[i];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_out <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      err    <= accept && !in_range;
      if (rd_acc) begin
        data_out <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_nibble_array.sv
// tb/tb_ram_nibble_array.sv - self-checking bench for ram_nibble_array
module tb_ram_nibble_array;

  logic       clk = 1'b0;
  logic       clr;
  logic       req;
  logic       rw;
  logic [2:0] addr;
  logic [1:0] nib_en;
  logic [7:0] data_in;
  logic       init;
  logic       run = 1'b0;

  logic       ready_a, rvalid_a, err_a, busy_a;
  logic [7:0] dout_a;
  logic       ready_b, rvalid_b, err_b, busy_b;
  logic [7:0] dout_b;

  int vectors = 0;
  int misses  = 0;

  always #5 clk = ~clk;

  // Instance a: 2 words, INIT 00 (sees only addr[0]); instance b: 5 words, INIT 5A.
  ram_nibble_array #(.WIDTH(8), .DEPTH(2), .INIT_VAL(8'h00)) dut_a (
    .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr[0:0]), .nib_en(nib_en),
    .data_in(data_in), .init(init), .ready(ready_a), .data_out(dout_a),
    .rvalid(rvalid_a), .err(err_a), .busy(busy_a)
  );

  ram_nibble_array #(.WIDTH(8), .DEPTH(5), .INIT_VAL(8'h5A)) dut_b (
    .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr), .nib_en(nib_en),
    .data_in(data_in), .init(init), .ready(ready_b), .data_out(dout_b),
    .rvalid(rvalid_b), .err(err_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem  [2][5];
  logic [7:0] m_dout [2];
  logic       m_rv   [2];
  logic       m_err  [2];
  int         m_left [2];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 5;
  endfunction

  function automatic logic [7:0] ival(input int k);
    return (k == 0) ? 8'h00 : 8'h5A;
  endfunction

  function automatic int eff(input int k);
    return (k == 0) ? int'(addr[0]) : int'(addr);
  endfunction

  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] d,
                                       input logic [1:0] en);
    return {en[1] ? d[7:4] : old[7:4], en[0] ? d[3:0] : old[3:0]};
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 5; i++) m_mem[k][i] <= 8'h00;
        m_dout[k] <= 8'h00;
        m_rv[k]   <= 1'b0;
        m_err[k]  <= 1'b0;
        m_left[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_rv[k]  <= 1'b0;
        m_err[k] <= 1'b0;
        if (m_left[k] > 0) begin
          m_mem[k][dep(k) - m_left[k]] <= ival(k);
          m_left[k] <= m_left[k] - 1;
        end else if (init) begin
          m_left[k] <= dep(k);
        end else if (req) begin
          if (eff(k) >= dep(k)) begin
            m_err[k] <= 1'b1;
            if (!rw) begin
              m_rv[k]   <= 1'b1;
              m_dout[k] <= 8'h00;
            end
          end else if (rw) begin
            m_mem[k][eff(k)] <= merge(m_mem[k][eff(k)], data_in, nib_en);
          end else begin
            m_rv[k]   <= 1'b1;
            m_dout[k] <= m_mem[k][eff(k)];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run) begin
      chk("a_data_out", 32'(dout_a),   32'(m_dout[0]));
      chk("a_rvalid",   32'(rvalid_a), 32'(m_rv[0]));
      chk("a_err",      32'(err_a),    32'(m_err[0]));
      chk("a_busy",     32'(busy_a),   32'(m_left[0] > 0));
      chk("a_ready",    32'(ready_a),  32'((m_left[0] == 0) && !init));
      chk("b_data_out", 32'(dout_b),   32'(m_dout[1]));
      chk("b_rvalid",   32'(rvalid_b), 32'(m_rv[1]));
      chk("b_err",      32'(err_b),    32'(m_err[1]));
      chk("b_busy",     32'(busy_b),   32'(m_left[1] > 0));
      chk("b_ready",    32'(ready_b),  32'((m_left[1] == 0) && !init));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic acc(input logic w, input logic [2:0] a, input logic [1:0] ne,
                     input logic [7:0] d);
    req = 1'b1; rw = w; addr = a; nib_en = ne; data_in = d;
    step();
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b) && n < 20) begin
      step();
      n++;
    end
    chk("sweep_finishes", 32'(busy_b), 32'd0);
  endtask

  initial begin
    int bcnt;
    clr = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; nib_en = '0; data_in = '0; init = 1'b0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    run = 1'b1;

    // Reset pulse mid-cycle
    step();
    clr = 1'b1;
    #1;
    chk("rst_dout", 32'(dout_a), 32'h00);
    chk("rst_busy", 32'(busy_a), 32'd0);
    clr = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_a), 32'd1);
    acc(1'b0, 3'd0, 2'b00, 8'h00);
    chk("rst_rd0_rvalid", 32'(rvalid_a), 32'd1);
    chk("rst_rd0", 32'(dout_a), 32'h00);
    acc(1'b0, 3'd1, 2'b00, 8'h00);
    chk("rst_rd1", 32'(dout_a), 32'h00);

    // Write / read
    acc(1'b1, 3'd1, 2'b11, 8'hA5);
    chk("wr_no_rvalid", 32'(rvalid_a), 32'd0);
    acc(1'b0, 3'd1, 2'b00, 8'h00);
    chk("wr_rd_rvalid", 32'(rvalid_a), 32'd1);
    chk("wr_rd_a", 32'(dout_a), 32'hA5);
    chk("wr_rd_b", 32'(dout_b), 32'hA5);

    // Nibble enables
    acc(1'b1, 3'd2, 2'b11, 8'h3C);
    acc(1'b1, 3'd2, 2'b10, 8'hF0);
    acc(1'b0, 3'd2, 2'b00, 8'h00);
    chk("nib_hi", 32'(dout_b), 32'hFC);
    acc(1'b1, 3'd2, 2'b00, 8'h11);
    acc(1'b0, 3'd2, 2'b00, 8'h00);
    chk("nib_none", 32'(dout_b), 32'hFC);

    // INIT sweep with req held throughout
    init = 1'b1; req = 1'b1; rw = 1'b0; addr = 3'd3;
    step();
    init = 1'b0;
    bcnt = busy_b ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!busy_b) break;
      bcnt++;
    end
    chk("sweep_busy_cycles", 32'(bcnt), 32'd5);
    chk("sweep_no_accept", 32'(rvalid_b), 32'd0);
    step();
    chk("sweep_first_idle_rvalid", 32'(rvalid_b), 32'd1);
    chk("sweep_first_idle_data", 32'(dout_b), 32'h5A);
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc(1'b0, 3'(i), 2'b00, 8'h00);
      chk("sweep_word", 32'(dout_b), 32'h5A);
    end

    // Out of range
    acc(1'b1, 3'd6, 2'b11, 8'h77);
    chk("oob_wr_err", 32'(err_b), 32'd1);
    acc(1'b0, 3'd6, 2'b00, 8'h00);
    chk("oob_rd_err", 32'(err_b), 32'd1);
    chk("oob_rd_rvalid", 32'(rvalid_b), 32'd1);
    chk("oob_rd_data", 32'(dout_b), 32'h00);
    for (int i = 0; i < 5; i++) begin
      acc(1'b0, 3'(i), 2'b00, 8'h00);
      chk("oob_word_kept", 32'(dout_b), 32'h5A);
    end

    // Back-to-back reads keep rvalid high
    req = 1'b1; rw = 1'b0; addr = 3'd0;
    step();
    addr = 3'd4;
    step();
    chk("b2b_rvalid", 32'(rvalid_b), 32'd1);
    req = 1'b0;

    // Fill with a distinct value, then clr mid-sweep at ptr=2
    acc(1'b1, 3'd3, 2'b11, 8'h99);
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    step();
    clr = 1'b1;
    #1;
    chk("clr_sweep_busy", 32'(busy_b), 32'd0);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc(1'b0, 3'(i), 2'b00, 8'h00);
      chk("clr_word_zero", 32'(dout_b), 32'h00);
    end
    init = 1'b1;
    step();
    init = 1'b0;
    wait_idle();
    acc(1'b0, 3'd2, 2'b00, 8'h00);
    chk("restart_sweep", 32'(dout_b), 32'h5A);

    step();
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
